rx_control_module: RTL

RX_CONTROL_MODULE -- requirements
Module: rx_control_module

---
 rtl/rx_control_module.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/rx_control_module.sv
`default_nettype none
// ============================================================================
//  Module   : rx_control_module
//  Purpose  : UART receive controller. Starts a frame on a start-edge pulse,
//             confirms the start bit at mid-bit, samples eight data bits
//             LSB first and one stop bit, then publishes the byte or flags
//             a framing error.
//  Ports    : CLK           - system clock, rising edge
//             RSTn          - asynchronous active-low reset
//             H2L_Sig       - one-cycle start-edge pulse from the edge detector
//             RX_Pin_In     - RX line level, synchronised to CLK
//             RX_En_Sig     - receive enable
//             RX_Data       - last correctly received byte
//             RX_Done_Sig   - one-cycle pulse, new byte on RX_Data
//             Frame_Err_Sig - one-cycle pulse, stop bit sampled low
//             Busy_Sig      - high while a frame is in progress
//  Revision : 1.0 - initial release
// ============================================================================
module rx_control_module #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       H2L_Sig,
    input  logic       RX_Pin_In,
    input  logic       RX_En_Sig,
    output logic [7:0] RX_Data,
    output logic       RX_Done_Sig,
    output logic       Frame_Err_Sig,
    output logic       Busy_Sig
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

    // The start bit is checked half a bit in; the counter starts one cycle
    // after the edge pulse, so mid-bit is reached at HALF-1.
    localparam logic [15:0] c_HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] c_BIT_M1  = 16'(CLKS_PER_BIT - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic [7:0]  r_data;
    logic        r_done;
    logic        r_err;

    logic        w_sample;
    logic        w_shift_en;
    logic        w_done_set;
    logic        w_err_set;

    // State register
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and sample-point decode. Dropping the enable aborts any
    // frame in progress before a sample can take effect.
    always_comb begin
        w_next_state = r_state;
        w_sample     = 1'b0;
        w_shift_en   = 1'b0;
        w_done_set   = 1'b0;
        w_err_set    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (H2L_Sig && RX_En_Sig) begin
                    w_next_state = c_ST_START;
                end
            end
            c_ST_START: begin
                if (!RX_En_Sig) begin
                    w_next_state = c_ST_IDLE;
                end else if (r_cnt == c_HALF_M1) begin
                    w_sample     = 1'b1;
                    // A high line at mid start bit is a glitch, not a frame.
                    w_next_state = RX_Pin_In ? c_ST_IDLE : c_ST_DATA;
                end
            end
            c_ST_DATA: begin
                if (!RX_En_Sig) begin
                    w_next_state = c_ST_IDLE;
                end else if (r_cnt == c_BIT_M1) begin
                    w_sample   = 1'b1;
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == 3'd7) begin
                        w_next_state = c_ST_STOP;
                    end
                end
            end
            c_ST_STOP: begin
                if (!RX_En_Sig) begin
                    w_next_state = c_ST_IDLE;
                end else if (r_cnt == c_BIT_M1) begin
                    w_sample     = 1'b1;
                    w_next_state = c_ST_IDLE;
                    w_done_set   = RX_Pin_In;
                    w_err_set    = ~RX_Pin_In;
                end
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // Bit timing, data path and output pulses
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_cnt     <= 16'd0;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_data    <= 8'h00;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if ((w_next_state != r_state) || w_sample) begin
                r_cnt <= 16'd0;
            end else if (r_state != c_ST_IDLE) begin
                r_cnt <= r_cnt + 16'd1;
            end

            if (r_state != c_ST_DATA) begin
                r_bit_cnt <= 3'd0;
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end

            if (w_shift_en) begin
                r_shift <= {RX_Pin_In, r_shift[7:1]};
            end

            if (w_done_set) begin
                r_data <= r_shift;
            end

            r_done <= w_done_set;
            r_err  <= w_err_set;
        end
    end

    assign RX_Data       = r_data;
    assign RX_Done_Sig   = r_done;
    assign Frame_Err_Sig = r_err;
    assign Busy_Sig      = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire
